// File: rtl/x_mul_unit.sv
// -----------------------------------------------------------------------------
// x_mul_unit
// Iterative radix-2 shift-add multiplier in the Execute stage. It produces
// x_alu_ready for the hazard unit. X, D and F are held while a multiply is in
// flight. The finished product is held until the X stage actually advances.
//
// Ports
//   clock      : single clock, all state updates on the rising edge
//   reset      : synchronous, active-high
//   start      : X holds a valid MUL
//   is_signed  : 1 = two's-complement operands, 0 = unsigned
//   operand_a  : multiplicand, sampled when a start is accepted
//   operand_b  : multiplier, sampled when a start is accepted
//   x_advance  : X pipeline register loads a new instruction this cycle
//   kill       : X instruction squashed; abort any operation
//   result_lo  : product bits [WIDTH-1:0]
//   result_hi  : product bits [2*WIDTH-1:WIDTH]
//   alu_ready  : 0 = hold the X stage
//   busy       : 1 while iterations are running
// -----------------------------------------------------------------------------
module x_mul_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             x_advance,
   input  logic             kill,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             alu_ready,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q,     state_d;
   logic [CNT_W-1:0] counter_q,   counter_d;
   logic [WIDTH-1:0] mcand_q,     mcand_d;
   logic [WIDTH-1:0] mplier_q,    mplier_d;
   logic [WIDTH-1:0] acc_hi_q,    acc_hi_d;
   logic             neg_q,       neg_d;
   logic [WIDTH-1:0] result_lo_q, result_lo_d;
   logic [WIDTH-1:0] result_hi_q, result_hi_d;

   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               load;
   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   acc_shift;
   logic [WIDTH-1:0]   mplier_shift;
   logic [2*WIDTH-1:0] product;
   logic [2*WIDTH-1:0] product_final;

   // Magnitudes of the operands. The most negative value negates to itself,
   // which read as unsigned is exactly its magnitude, so no extra bit is needed.
   always_comb begin
      a_mag = operand_a;
      b_mag = operand_b;
      if (is_signed && operand_a[WIDTH-1]) a_mag = -operand_a;
      if (is_signed && operand_b[WIDTH-1]) b_mag = -operand_b;
   end

   // A new multiply is accepted from IDLE, or from DONE when X advances
   // with another MUL behind it. kill always wins.
   assign load = start && !kill &&
                 ((state_q == S_IDLE) || ((state_q == S_DONE) && x_advance));

   // One shift-add iteration. The add is WIDTH+1 bits wide; its carry becomes
   // the top bit of the accumulator after the right shift.
   always_comb begin
      sum           = {1'b0, acc_hi_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
      acc_shift     = sum[WIDTH:1];
      mplier_shift  = {sum[0], mplier_q[WIDTH-1:1]};
      product       = {acc_shift, mplier_shift};
      product_final = neg_q ? -product : product;
   end

   always_comb begin
      state_d     = state_q;
      counter_d   = counter_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_hi_d    = acc_hi_q;
      neg_d       = neg_q;
      result_lo_d = result_lo_q;
      result_hi_d = result_hi_q;

      case (state_q)
         S_IDLE: begin
            if (load) state_d = S_BUSY;
         end
         S_BUSY: begin
            acc_hi_d  = acc_shift;
            mplier_d  = mplier_shift;
            counter_d = counter_q + 1'b1;
            if (counter_q == LAST_ITER) begin
               state_d     = S_DONE;
               result_lo_d = product_final[WIDTH-1:0];
               result_hi_d = product_final[2*WIDTH-1:WIDTH];
            end
         end
         S_DONE: begin
            if (x_advance) state_d = load ? S_BUSY : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (load) begin
         mcand_d   = a_mag;
         mplier_d  = b_mag;
         acc_hi_d  = '0;
         counter_d = '0;
         neg_d     = is_signed && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
      end

      // Abort: drop the partial product; the last finished result stays.
      if (kill) begin
         state_d   = S_IDLE;
         counter_d = '0;
         acc_hi_d  = '0;
      end
   end

   always_ff @(posedge clock) begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_hi_q <= acc_hi_d;
      neg_q    <= neg_d;
      if (reset) begin
         state_q     <= S_IDLE;
         counter_q   <= '0;
         result_lo_q <= '0;
         result_hi_q <= '0;
      end else begin
         state_q     <= state_d;
         counter_q   <= counter_d;
         result_lo_q <= result_lo_d;
         result_hi_q <= result_hi_d;
      end
   end

   assign result_lo = result_lo_q;
   assign result_hi = result_hi_q;
   assign busy      = (state_q == S_BUSY);

   // In IDLE a waiting MUL must stall X in the same cycle it shows up.
   always_comb begin
      alu_ready = 1'b1;
      case (state_q)
         S_IDLE:  alu_ready = !start;
         S_BUSY:  alu_ready = 1'b0;
         S_DONE:  alu_ready = 1'b1;
         default: alu_ready = 1'b1;
      endcase
   end

endmodule
